// File: rtl/wb_mem_writer_pkg.sv
// Shared constants and types for the write-back drain path and the memory-side writer.
package wb_mem_writer_pkg;

    localparam int DATA_WIDTH = 128;
    localparam int LINE_WIDTH = DATA_WIDTH;
    localparam int ADDR_WIDTH = 32;
    localparam int BUS_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2
    } wbw_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LINE_WIDTH-1:0] data;
    } wb_line_t;

    // Beat counter needs at least one bit even for single-beat lines.
    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/wb_mem_writer_if.sv
// Drain-side handshake plus memory-side burst write request/grant/response signals.
interface wb_mem_writer_if #(
    parameter int LINE_WIDTH = wb_mem_writer_pkg::LINE_WIDTH,
    parameter int BUS_WIDTH  = wb_mem_writer_pkg::BUS_WIDTH,
    parameter int ADDR_WIDTH = wb_mem_writer_pkg::ADDR_WIDTH
) ();

    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;

    logic                  mem_req;
    logic                  mem_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [BUS_WIDTH-1:0]  mem_wdata;
    logic                  mem_last;
    logic                  mem_rsp_valid;
    logic                  mem_rsp_err;

    // The writer masters the memory bus and consumes the drain port.
    modport master (
        input  valid, addr, data, mem_gnt, mem_rsp_valid, mem_rsp_err,
        output ready, mem_req, mem_addr, mem_wdata, mem_last
    );

    modport slave (
        output valid, addr, data, mem_gnt, mem_rsp_valid, mem_rsp_err,
        input  ready, mem_req, mem_addr, mem_wdata, mem_last
    );

endinterface

// File: rtl/wb_mem_writer.sv
// Drains one dirty line at a time from the write-back buffer and writes it as a burst.
// Optional statistics counters are enabled with `define WB_MEM_WRITER_STATS_EN.
//
// state    | meaning
// IDLE     | ready for a line; captures it on valid
// SEND     | presenting beat beat_cnt until granted
// WAIT_RSP | burst done, waiting for the single write response
module wb_mem_writer #(
    parameter int LINE_WIDTH = wb_mem_writer_pkg::LINE_WIDTH,
    parameter int BUS_WIDTH  = wb_mem_writer_pkg::BUS_WIDTH,
    parameter int ADDR_WIDTH = wb_mem_writer_pkg::ADDR_WIDTH
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_mem_writer_if.master bus,
    output logic            busy_o,
    output logic            err_o
`ifdef WB_MEM_WRITER_STATS_EN
    ,
    output logic [31:0]     lines_written_o,
    output logic [31:0]     gnt_stall_cycles_o
`endif
);
    import wb_mem_writer_pkg::*;

    localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int OFS   = $clog2(LINE_WIDTH / 8);
    localparam int BOFS  = $clog2(BUS_WIDTH / 8);
    localparam int CNT_W = cnt_width(BEATS);
    localparam int SEL_W = $clog2(LINE_WIDTH);

    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~((ADDR_WIDTH'(1) << OFS) - ADDR_WIDTH'(1));

    wbw_state_e            state_q;
    wbw_state_e            state_d;
    logic [CNT_W-1:0]      beat_cnt_q;
    logic [ADDR_WIDTH-1:0] line_addr_q;
    logic [LINE_WIDTH-1:0] line_data_q;
    logic                  err_q;

    logic                  accept;
    logic                  beat_done;
    logic                  last_beat;
    logic                  rsp_take;
    logic [SEL_W-1:0]      bit_ofs;
    logic [ADDR_WIDTH-1:0] beat_addr;

    assign accept    = (state_q == IDLE) && bus.valid;
    assign beat_done = (state_q == SEND) && bus.mem_gnt;
    assign rsp_take  = (state_q == WAIT_RSP) && bus.mem_rsp_valid;
    assign last_beat = (beat_cnt_q == LAST_BEAT);
    assign bit_ofs   = SEL_W'(beat_cnt_q) << $clog2(BUS_WIDTH);
    assign beat_addr = line_addr_q + (ADDR_WIDTH'(beat_cnt_q) << BOFS);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (bus.valid) state_d = SEND;
            SEND:     if (bus.mem_gnt && last_beat) state_d = WAIT_RSP;
            WAIT_RSP: if (bus.mem_rsp_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Outputs decode from state only so ready never depends on valid.
    always_comb begin
        bus.ready     = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_last  = 1'b0;
        busy_o        = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                busy_o    = 1'b0;
            end
            SEND: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = beat_addr;
                bus.mem_wdata = line_data_q[bit_ofs +: BUS_WIDTH];
                bus.mem_last  = last_beat;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_cnt_q  <= '0;
            line_addr_q <= '0;
            line_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= rsp_take && bus.mem_rsp_err;
            if (accept) begin
                line_addr_q <= bus.addr & LINE_MASK;
                line_data_q <= bus.data;
                beat_cnt_q  <= '0;
            end else if (beat_done && !last_beat) begin
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
        end
    end

    assign err_o = err_q;

`ifdef WB_MEM_WRITER_STATS_EN
    logic [31:0] lines_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lines_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (rsp_take && !bus.mem_rsp_err && (lines_q != 32'hFFFF_FFFF)) begin
                lines_q <= lines_q + 32'd1;
            end
            if ((state_q == SEND) && !bus.mem_gnt && (stalls_q != 32'hFFFF_FFFF)) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign lines_written_o    = lines_q;
    assign gnt_stall_cycles_o = stalls_q;
`endif

endmodule

// File: tb/tb_wb_mem_writer.sv
// Directed bench for wb_mem_writer: vector table for single lines, hand sequences for multi-line and reset.
module tb_wb_mem_writer;
    import wb_mem_writer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic err;
`ifdef WB_MEM_WRITER_STATS_EN
    logic [31:0] lines_written;
    logic [31:0] gnt_stalls;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_mem_writer_if bus_if ();

    wb_mem_writer dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus_if.master),
        .busy_o (busy),
        .err_o  (err)
`ifdef WB_MEM_WRITER_STATS_EN
        ,
        .lines_written_o    (lines_written),
        .gnt_stall_cycles_o (gnt_stalls)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] addr;
        logic [127:0] data;
        logic        gnt;
        logic        rv;
        logic        re;
        logic        e_ready;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_last;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic v_idle(input logic valid, input wb_line_t ln, input logic gnt,
                          input logic rv, input logic re, input logic e_err);
        vec_t v;
        v = '{valid, ln.addr, ln.data, gnt, rv, re,
              1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, e_err};
        vq.push_back(v);
    endtask

    task automatic v_send(input wb_line_t ln, input int b, input logic gnt,
                          input logic rv, input logic re);
        vec_t v;
        logic [31:0] a;
        logic [31:0] d;
        a = (ln.addr & 32'hFFFF_FFF0) + 32'(b * 4);
        d = ln.data[b*32 +: 32];
        v = '{1'b0, 32'h0, 128'h0, gnt, rv, re,
              1'b0, 1'b1, a, d, (b == 3), 1'b1, 1'b0};
        vq.push_back(v);
    endtask

    task automatic v_wait(input logic gnt, input logic rv, input logic re);
        vec_t v;
        v = '{1'b0, 32'h0, 128'h0, gnt, rv, re,
              1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0};
        vq.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [31:0] addr, input logic [127:0] data,
                         input logic gnt, input logic rv, input logic re);
        bus_if.valid         = valid;
        bus_if.addr          = addr;
        bus_if.data          = data;
        bus_if.mem_gnt       = gnt;
        bus_if.mem_rsp_valid = rv;
        bus_if.mem_rsp_err   = re;
    endtask

    wb_line_t la, lb, lc, ld, le, lz;
    wb_line_t q3 [3];

    initial begin
        la = '{addr: 32'h1000_0047, data: 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA};
        lb = '{addr: 32'h2000_0010, data: 128'h44444444_33333333_22222222_11111111};
        lc = '{addr: 32'hFFFF_FFF5, data: 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909};
        ld = '{addr: 32'h4000_0020, data: 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0};
        le = '{addr: 32'h5000_003C, data: 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0};
        lz = '0;
        q3[0] = '{addr: 32'h3000_0005, data: 128'h13131313_12121212_11111111_10101010};
        q3[1] = '{addr: 32'h3000_0013, data: 128'h23232323_22222222_21212121_20202020};
        q3[2] = '{addr: 32'h3000_002F, data: 128'h33333333_32323232_31313131_30303030};

        // Line A: full grants, clean response, then spurious grant/response in IDLE.
        v_idle(1'b1, la, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 4; b++) v_send(la, b, 1'b1, 1'b0, 1'b0);
        v_wait(1'b1, 1'b0, 1'b0);
        v_wait(1'b0, 1'b1, 1'b0);
        v_idle(1'b0, lz, 1'b1, 1'b1, 1'b1, 1'b0);
        v_idle(1'b0, lz, 1'b0, 1'b0, 1'b0, 1'b0);
        // Line B: 3-cycle stall on beat 1 with a spurious error response inside it, then error response.
        v_idle(1'b1, lb, 1'b0, 1'b0, 1'b0, 1'b0);
        v_send(lb, 0, 1'b1, 1'b0, 1'b0);
        v_send(lb, 1, 1'b0, 1'b0, 1'b0);
        v_send(lb, 1, 1'b0, 1'b1, 1'b1);
        v_send(lb, 1, 1'b0, 1'b0, 1'b0);
        v_send(lb, 1, 1'b1, 1'b0, 1'b0);
        v_send(lb, 2, 1'b1, 1'b0, 1'b0);
        v_send(lb, 3, 1'b1, 1'b0, 1'b0);
        v_wait(1'b0, 1'b1, 1'b1);
        // Line C accepted in the err_o cycle; its beats sit at the top of the address space.
        v_idle(1'b1, lc, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) v_send(lc, b, 1'b1, 1'b0, 1'b0);
        v_wait(1'b0, 1'b1, 1'b0);
        v_idle(1'b0, lz, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b0, 32'h0, 128'h0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #2;
        chk("rst ready", 32'(bus_if.ready), 32'd1);
        chk("rst req", 32'(bus_if.mem_req), 32'd0);
        chk("rst last", 32'(bus_if.mem_last), 32'd0);
        chk("rst addr", bus_if.mem_addr, 32'h0);
        chk("rst wdata", bus_if.mem_wdata, 32'h0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vq[i].valid, vq[i].addr, vq[i].data, vq[i].gnt, vq[i].rv, vq[i].re);
            @(negedge clk);
            chk($sformatf("v%0d ready", i), 32'(bus_if.ready), 32'(vq[i].e_ready));
            chk($sformatf("v%0d req", i), 32'(bus_if.mem_req), 32'(vq[i].e_req));
            chk($sformatf("v%0d addr", i), bus_if.mem_addr, vq[i].e_addr);
            chk($sformatf("v%0d wdata", i), bus_if.mem_wdata, vq[i].e_wdata);
            chk($sformatf("v%0d last", i), 32'(bus_if.mem_last), 32'(vq[i].e_last));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
            chk($sformatf("v%0d err", i), 32'(err), 32'(vq[i].e_err));
        end
`ifdef WB_MEM_WRITER_STATS_EN
        chk("stats lines", lines_written, 32'd2);
        chk("stats stalls", gnt_stalls, 32'd3);
`endif

        // Back-to-back: valid held with three queued lines, response two cycles into WAIT_RSP.
        begin
            int  li       = 0;
            int  exp_line = 0;
            int  exp_beat = 0;
            int  beats    = 0;
            int  rsp_done = 0;
            int  wait_cnt = 0;
            int  cycles   = 0;
            bit  pend     = 1'b0;
            logic v_now;
            logic rv_now;
            while (rsp_done < 3 && cycles < 200) begin
                @(posedge clk);
                #1;
                v_now  = (li < 3);
                rv_now = pend && (wait_cnt == 1);
                drive(v_now, (li < 3) ? q3[li].addr : 32'h0, (li < 3) ? q3[li].data : 128'h0,
                      1'b1, rv_now, 1'b0);
                @(negedge clk);
                cycles++;
                if (pend && bus_if.ready) chk("b2b ready while pending", 32'(bus_if.ready), 32'd0);
                if (bus_if.ready && v_now) li++;
                if (pend && rv_now) begin
                    pend = 1'b0;
                    rsp_done++;
                end else if (pend) begin
                    wait_cnt++;
                end
                if (bus_if.mem_req) begin
                    if (pend) chk("b2b beat before rsp", 32'(bus_if.mem_req), 32'd0);
                    chk($sformatf("b2b l%0d b%0d addr", exp_line, exp_beat), bus_if.mem_addr,
                        (q3[exp_line].addr & 32'hFFFF_FFF0) + 32'(exp_beat * 4));
                    chk($sformatf("b2b l%0d b%0d data", exp_line, exp_beat), bus_if.mem_wdata,
                        q3[exp_line].data[exp_beat*32 +: 32]);
                    chk($sformatf("b2b l%0d b%0d last", exp_line, exp_beat),
                        32'(bus_if.mem_last), 32'(exp_beat == 3));
                    beats++;
                    exp_beat++;
                    if (exp_beat == 4) begin
                        exp_beat = 0;
                        exp_line = (exp_line < 2) ? exp_line + 1 : exp_line;
                        pend     = 1'b1;
                        wait_cnt = 0;
                    end
                end
            end
            chk("b2b responses", 32'(rsp_done), 32'd3);
            chk("b2b beats", 32'(beats), 32'd12);
            chk("b2b cycles", 32'(cycles), 32'd21);
        end

        // Reset after two beats granted; beat 2 is on the bus when reset hits.
        @(posedge clk);
        #1 drive(1'b1, ld.addr, ld.data, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmid beat0 addr", bus_if.mem_addr, 32'h4000_0020);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid beat1 addr", bus_if.mem_addr, 32'h4000_0024);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 128'h0, 1'b0, 1'b0, 1'b0);
        chk("rstmid beat2 req before rst", 32'(bus_if.mem_req), 32'd1);
        chk("rstmid beat2 addr", bus_if.mem_addr, 32'h4000_0028);
        rst = 1'b1;
        #1;
        chk("rstmid req async", 32'(bus_if.mem_req), 32'd0);
        chk("rstmid busy async", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid ready after", 32'(bus_if.ready), 32'd1);
        chk("rstmid busy after", 32'(busy), 32'd0);
        chk("rstmid req after", 32'(bus_if.mem_req), 32'd0);
        @(posedge clk);
        #1 drive(1'b1, le.addr, le.data, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(1'b0, 32'h0, 128'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("rstmid next req", 32'(bus_if.mem_req), 32'd1);
        chk("rstmid next addr", bus_if.mem_addr, 32'h5000_0030);
        chk("rstmid next data", bus_if.mem_wdata, 32'hE0E0E0E0);
        chk("rstmid next last", 32'(bus_if.mem_last), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_mem_writer.md
Name: wb_mem_writer

Overview:
- Downstream consumer of the write-back buffer's drain port (valid/ready/addr/data).
- Takes one evicted dirty cache line per handshake and splits it into BUS_WIDTH beats.
- Issues the beats as a burst write on the memory-side request/grant interface, then waits for a single write response before accepting the next line.
- Keeps at most one line in flight, so the buffer's entry stays valid, and hit-visible, until the writer has taken it.

Parameters:
LINE_WIDTH, DATA_WIDTH (cache_pkg), cache line width in bits; must be a multiple of BUS_WIDTH
BUS_WIDTH, 32, memory data bus width in bits; power of two, ≥8
ADDR_WIDTH, ADDR_WIDTH (cache_pkg), byte address width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous, active-high reset
valid_i  in  1  line available from write-back buffer
ready_o  out  1  writer accepts line this cycle
addr_i  in  ADDR_WIDTH  line byte address
data_i  in  LINE_WIDTH  line data, beat 0 = bits [BUS_WIDTH-1:0]
mem_req_o  out  1  beat request valid
mem_gnt_i  in  1  beat accepted by memory
mem_addr_o  out  ADDR_WIDTH  beat byte address
mem_wdata_o  out  BUS_WIDTH  beat data
mem_last_o  out  1  current beat is final beat of line
mem_rsp_valid_i  in  1  write response for whole line
mem_rsp_err_i  in  1  response carries error (qualified by mem_rsp_valid_i)
busy_o  out  1  state != IDLE
err_o  out  1  one-cycle pulse on error response

Behaviour:
- BEATS = LINE_WIDTH/BUS_WIDTH; OFS = log2(LINE_WIDTH/8); BOFS = log2(BUS_WIDTH/8). Beat counter width = max(1, log2(BEATS)).
- Reset (async, rst_i=1): state=IDLE, beat_cnt=0. Outputs: ready_o=1, mem_req_o=0, mem_last_o=0, busy_o=0, err_o=0; mem_addr_o and mem_wdata_o are 0.
- FSM states: IDLE, SEND, WAIT_RSP.
- IDLE:
  - ready_o=1, combinational from state only; never depends on valid_i.
  - On valid_i: capture addr_i with bits [OFS-1:0] forced to 0, capture data_i, clear beat_cnt, go to SEND.
- SEND:
  - mem_req_o=1.
  - mem_addr_o = line_addr + beat_cnt·(BUS_WIDTH/8).
  - mem_wdata_o = line[beat_cnt·BUS_WIDTH +: BUS_WIDTH].
  - mem_last_o = (beat_cnt == BEATS-1).
  - Request, address, data and last stay stable until mem_gnt_i.
  - On mem_gnt_i with !last: beat_cnt+1. Next beat is presented the following cycle with no bubble.
  - On mem_gnt_i with last: go to WAIT_RSP and deassert mem_req_o next cycle.
  - BEATS=1: the single beat has mem_last_o=1.
- WAIT_RSP:
  - mem_req_o=0, ready_o=0.
  - On mem_rsp_valid_i: go to IDLE. err_o=1 for exactly that next cycle if mem_rsp_err_i=1. The line is dropped either way; there is no retry.
- mem_rsp_valid_i outside WAIT_RSP is ignored. mem_gnt_i outside SEND is ignored.
- Latency: line accepted at cycle t → first beat requested at t+1 → with grants every cycle, last beat granted at t+BEATS → ready_o high again the cycle after the response.
- Throughput: one line per (BEATS + response latency + 1) cycles minimum. Back-to-back lines are allowed, with no idle cycle beyond IDLE itself.
- Reset mid-operation: line and counters are discarded immediately, mem_req_o drops asynchronously, and the line is not replayed.
- Beat address arithmetic wraps mod 2^ADDR_WIDTH. It cannot cross the line because the offset is forced to 0.

Optional Feature:
- Macro WB_MEM_WRITER_STATS_EN.
- When defined, adds two 32-bit outputs:
  - lines_written_o: increments on each response with !err.
  - gnt_stall_cycles_o: increments each SEND cycle with mem_gnt_i=0.
  - Both reset to 0 and saturate at 2^32-1.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- In cache_pkg:
  - BUS_WIDTH default constant.
  - wbw_state_e enum {IDLE, SEND, WAIT_RSP}.
  - wb_line_t struct {addr, data}, shared with the buffer's drain side.
- No sub-module. The beat mux is an indexed part-select inside this module. Stats counters stay inline under the macro.

Test Plan:
1. LINE 128, BUS 32; valid_i with addr 0x1000_0047, data 0xDDDD…_CCCC…_BBBB…_AAAA…, gnt tied high → 4 beats at 0x1000_0040/44/48/4C carrying AAAA, BBBB, CCCC, DDDD; mem_last_o only on 4th; ready_o low until the cycle after mem_rsp_valid_i.
2. Grant stalls: hold mem_gnt_i low 3 cycles on beat 1 → mem_addr_o=…44 and data stable all 3 cycles; beat_cnt does not advance; stats gnt_stall_cycles_o=3.
3. Error response: mem_rsp_valid_i=1 with mem_rsp_err_i=1 → err_o high exactly 1 cycle; next line accepted normally; lines_written_o unchanged.
4. Back-to-back: valid_i held with 3 queued lines, 2-cycle response latency → 3 bursts, 12 granted beats, no beat of line n+1 before response of line n.
5. Reset mid-burst: assert rst_i after beat 2 granted → mem_req_o=0 same cycle; after release ready_o=1, busy_o=0; the next line starts at beat 0.
6. Spurious mem_rsp_valid_i during SEND and a spurious mem_gnt_i in IDLE → no state change, no err_o.
